cmp_serial: RTL

- Multi-cycle magnitude comparator for WIDTH-bit unsigned operands.
- Sits directly downstream of the operand source and upstream of the existing 2-bit comparator stage, cmp2.
- Each cycle it slices one 2-bit pair per operand, MSB pair first, into cmp2 and consumes cmp2's greater/less outputs.
- Accumulates a single greater/less/equal verdict, presented on valid/ready handshakes at both input and output.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp2.sv | 17 +
 rtl/cmp_serial.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package cmp_pkg;

  // Controller states: waiting for operands, scanning pairs, holding a verdict.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Bits examined per cycle; matches the width of the cmp2 stage.
  localparam int PAIR_W = 2;

  // Pair counter must hold WIDTH/2 down to 1, so size it for WIDTH/2 + 1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width / PAIR_W + 1);
  endfunction

endpackage

// File: rtl/cmp2.sv
// Two-bit unsigned comparator used as the per-pair decision stage.
module cmp2
  import cmp_pkg::*;
(
  input  logic [PAIR_W-1:0] a_i,
  input  logic [PAIR_W-1:0] b_i,
  output logic              greater_o,
  output logic              less_o
);

  // Pure combinational compare; equality is implied when neither flag is raised.
  always_comb begin
    greater_o = (a_i > b_i);
    less_o    = (a_i < b_i);
  end

endmodule

// File: rtl/cmp_serial.sv
// Multi-cycle unsigned magnitude comparator: scans one 2-bit pair per cycle,
// MSB pair first, through cmp2 and reports greater/less/equal on a
// valid/ready handshake.
// Optional build macro: CMP_SERIAL_EARLY_EXIT_EN -- when defined, the verdict
// is issued on the cycle the first differing pair is seen instead of after
// the full WIDTH/2-cycle scan.
module cmp_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int NPAIR = WIDTH / PAIR_W;

  // Odd or sub-pair widths cannot be sliced into whole pairs.
  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("cmp_serial: WIDTH must be even and at least 2");
    end
  endgenerate

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             greater_q, greater_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             out_valid_q, out_valid_d;

  logic             pair_gt_s;
  logic             pair_lt_s;
  logic             new_decision_s;
  logic             last_pair_s;
  logic             finish_s;

  // Top pair of each shift register is always the one under evaluation.
  cmp2 u_cmp2 (
    .a_i       (sa_q[WIDTH-1 -: PAIR_W]),
    .b_i       (sb_q[WIDTH-1 -: PAIR_W]),
    .greater_o (pair_gt_s),
    .less_o    (pair_lt_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    greater_d   = greater_q;
    less_d      = less_q;
    equal_d     = equal_q;
    out_valid_d = out_valid_q;

    // A verdict is only taken from the first differing pair; later pairs are masked.
    new_decision_s = !decided_q && (pair_gt_s || pair_lt_s);
    last_pair_s    = (cnt_q == CNT_W'(1));
`ifdef CMP_SERIAL_EARLY_EXIT_EN
    finish_s       = last_pair_s || new_decision_s;
`else
    finish_s       = last_pair_s;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d      = a;
          sb_d      = b;
          cnt_d     = CNT_W'(NPAIR);
          decided_d = 1'b0;
          greater_d = 1'b0;
          less_d    = 1'b0;
          equal_d   = 1'b0;
          state_d   = RUN;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        sa_d  = sa_q << PAIR_W;
        sb_d  = sb_q << PAIR_W;
        cnt_d = cnt_q - CNT_W'(1);
        if (new_decision_s) begin
          greater_d = pair_gt_s;
          less_d    = pair_lt_s;
          decided_d = 1'b1;
        end else begin
          decided_d = decided_q;
        end
        if (finish_s) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          equal_d     = !decided_q && !new_decision_s;
        end else begin
          state_d     = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      greater_q   <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      greater_q   <= greater_d;
      less_q      <= less_d;
      equal_q     <= equal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign greater   = greater_q;
  assign less      = less_q;
  assign equal     = equal_q;

endmodule
